instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/seq_pkg.sv | 53 +++++
 rtl/seq_timeout.sv | 31 +++
 rtl/instr_sequencer.sv | 158 +++++++++++++++
 tb/tb_instr_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared encodings for the instruction sequencer: FSM states, PC control,
// writeback source, the decoded-control bundle and small decode helpers.
package seq_pkg;

    // Wide enough for any TIMEOUT in 1..255.
    localparam int WAIT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        PC_NORMAL   = 2'd0,
        PC_SET_STEP = 2'd1,
        PC_SET_REF  = 2'd2
    } pc_cfg_t;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_LOAD = 2'd1,
        SRC_PC   = 2'd2
    } reg_src_t;

    // Decoded controls captured at the end of DECODE.
    typedef struct packed {
        pc_cfg_t  pc_cfg;
        logic     ram_store;
        logic     reg_write;
        reg_src_t reg_src;
    } ctrl_t;

    // A store or a load both need a data-memory transaction.
    function automatic logic needs_mem(ctrl_t c);
        return c.ram_store || (c.reg_src == SRC_LOAD);
    endfunction

    // Branches and jumps without writeback finish in EXECUTE.
    function automatic logic ends_in_execute(ctrl_t c);
        return !needs_mem(c) && !c.reg_write;
    endfunction

    // A conditional branch that is not taken falls through to the normal PC.
    function automatic logic [1:0] pc_select(pc_cfg_t cfg, logic flag);
        return ((cfg == PC_SET_STEP) && !flag) ? 2'(PC_NORMAL) : 2'(cfg);
    endfunction

endpackage

// File: rtl/seq_timeout.sv
// Wait-state watchdog: counts cycles spent waiting for an ack and flags the
// TIMEOUT-th cycle so the control unit can give up on the transaction.
module seq_timeout
    import seq_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expire
);

    logic [WAIT_W-1:0] wait_cnt;

    // Wait counter: zero on clear, advance once per un-acked wait cycle.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (reset || clear) begin
            wait_cnt <= '0;
        end else if (count) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // The counter reads N-1 during the N-th cycle of a wait.
    assign expire = (wait_cnt == WAIT_W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: walks FETCH/DECODE/EXECUTE/MEM/WRITEBACK
// for each instruction, drives memory requests and register/PC strobes,
// counts retired instructions and parks in FAULT if a memory never answers.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       pcconfig,
    input  logic             ramconfig,
    input  logic             regbankconfig,
    input  logic [1:0]       regsource,
    input  logic             alu_flag,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_load,
    output logic             pc_write,
    output logic [1:0]       pc_sel,
    output logic             reg_write,
    output logic [1:0]       reg_sel,
    output logic             busy,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    state_t state_q;
    state_t state_next;
    state_t end_state;
    ctrl_t  ctrl_q;
    ctrl_t  ctrl_next;
    logic   flag_q;
    logic   flag_eff;
    logic   stop_q;
    logic   pc_write_q;
    logic   pc_write_mem;
    logic   wait_count;
    logic   wait_clear;
    logic   wait_expire;

    // Next-state and next-control selection.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_next = state_q;
        ctrl_next  = ctrl_q;
        // A stop seen in the final cycle counts just like an earlier one.
        end_state  = (stop_q || stop) ? ST_IDLE : ST_FETCH;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack)         state_next = ST_DECODE;
                else if (wait_expire) state_next = ST_FAULT;
            end
            ST_DECODE: begin
                ctrl_next.pc_cfg    = pc_cfg_t'(pcconfig);
                ctrl_next.ram_store = ramconfig;
                ctrl_next.reg_write = regbankconfig;
                ctrl_next.reg_src   = reg_src_t'(regsource);
                state_next          = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (needs_mem(ctrl_q))     state_next = ST_MEM;
                else if (ctrl_q.reg_write) state_next = ST_WRITEBACK;
                else                       state_next = end_state;
            end
            ST_MEM: begin
                if (dmem_ack)         state_next = ctrl_q.reg_write ? ST_WRITEBACK : end_state;
                else if (wait_expire) state_next = ST_FAULT;
            end
            ST_WRITEBACK: state_next = end_state;
            ST_FAULT:     state_next = ST_FAULT;
            default:      state_next = ST_IDLE;
        endcase
    end

    // The watchdog runs only while we remain in the same wait state; any
    // other transition (including entry into FETCH or MEM) zeroes it.
    assign wait_count = ((state_q == ST_FETCH) && (state_next == ST_FETCH)) ||
                        ((state_q == ST_MEM)   && (state_next == ST_MEM));
    assign wait_clear = !wait_count;

    seq_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (wait_clear),
        .count  (wait_count),
        .expire (wait_expire)
    );

    // State, captured controls, stop latch, retire counter and the Moore
    // outputs, which are registered from the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            flag_q     <= 1'b0;
            stop_q     <= 1'b0;
            retired    <= '0;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            reg_write  <= 1'b0;
            reg_sel    <= 2'd0;
            busy       <= 1'b0;
            fault      <= 1'b0;
            pc_write_q <= 1'b0;
        end else begin
            state_q <= state_next;
            ctrl_q  <= ctrl_next;
            if (state_q == ST_EXECUTE) flag_q <= alu_flag;

            if (state_next == ST_IDLE) begin
                stop_q <= 1'b0;
            end else if (stop && (state_q != ST_IDLE) && (state_q != ST_FAULT)) begin
                stop_q <= 1'b1;
            end

            if (pc_write) retired <= retired + CNT_W'(1);

            imem_req   <= (state_next == ST_FETCH);
            dmem_req   <= (state_next == ST_MEM);
            dmem_we    <= (state_next == ST_MEM) && ctrl_next.ram_store;
            reg_write  <= (state_next == ST_WRITEBACK);
            reg_sel    <= (state_next == ST_WRITEBACK) ? 2'(ctrl_next.reg_src) : 2'd0;
            busy       <= (state_next != ST_IDLE) && (state_next != ST_FAULT);
            fault      <= (state_next == ST_FAULT);
            pc_write_q <= (state_next == ST_WRITEBACK) ||
                          ((state_next == ST_EXECUTE) && ends_in_execute(ctrl_next));
        end
    end

    // A store without writeback ends on the very cycle its ack arrives, so
    // that PC update cannot be known a cycle ahead.
    assign pc_write_mem = (state_q == ST_MEM) && dmem_ack && !ctrl_q.reg_write;
    assign pc_write     = pc_write_q || pc_write_mem;

    // A branch that ends in EXECUTE resolves with the flag being captured on
    // that same edge; later cycles use the captured copy.
    assign flag_eff = (state_q == ST_EXECUTE) ? alu_flag : flag_q;
    assign pc_sel   = pc_write ? pc_select(ctrl_q.pc_cfg, flag_eff) : 2'd0;

    assign ir_load  = (state_q == ST_FETCH) && imem_ack;
    assign state    = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: drives instructions with chosen
// ack latencies, queues the expected end-of-instruction strobes and compares
// them whenever the DUT raises pc_write.
module tb_instr_sequencer;
    import seq_pkg::*;

    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic             stop;
    logic [1:0]       pcconfig;
    logic             ramconfig;
    logic             regbankconfig;
    logic [1:0]       regsource;
    logic             alu_flag;
    logic             imem_ack;
    logic             dmem_ack;
    logic             imem_req;
    logic             dmem_req;
    logic             dmem_we;
    logic             ir_load;
    logic             pc_write;
    logic [1:0]       pc_sel;
    logic             reg_write;
    logic [1:0]       reg_sel;
    logic             busy;
    logic             fault;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    typedef struct {
        logic [1:0] pc_sel;
        logic       reg_write;
        logic [1:0] reg_sel;
    } exp_t;

    exp_t             sb_q[$];
    logic [CNT_W-1:0] exp_retired = '0;
    int               n_tests = 0;
    int               n_fail  = 0;

    instr_sequencer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .pcconfig      (pcconfig),
        .ramconfig     (ramconfig),
        .regbankconfig (regbankconfig),
        .regsource     (regsource),
        .alu_flag      (alu_flag),
        .imem_ack      (imem_ack),
        .dmem_ack      (dmem_ack),
        .imem_req      (imem_req),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .ir_load       (ir_load),
        .pc_write      (pc_write),
        .pc_sel        (pc_sel),
        .reg_write     (reg_write),
        .reg_sel       (reg_sel),
        .busy          (busy),
        .fault         (fault),
        .state         (state),
        .retired       (retired)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: runs at the falling edge of every cycle.
    task automatic sb_monitor();
        exp_t e;
        if (reset) begin
            sb_q.delete();
            exp_retired = '0;
        end else if (pc_write) begin
            check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("end_pc_sel", 32'(pc_sel), 32'(e.pc_sel));
                check("end_reg_write", 32'(reg_write), 32'(e.reg_write));
                check("end_reg_sel", 32'(reg_sel), 32'(e.reg_sel));
                check("end_retired", 32'(retired), 32'(exp_retired));
                exp_retired = exp_retired + CNT_W'(1);
            end
        end
    endtask

    // One clock: monitor at the falling edge, then land 2 units past the
    // next rising edge where inputs are driven.
    task automatic tick();
        @(negedge clock);
        sb_monitor();
        @(posedge clock);
        #2;
    endtask

    // Drive one whole instruction starting in its first FETCH cycle.
    task automatic run_instr(input logic [1:0] pc, input logic ram, input logic rb,
                             input logic [1:0] src, input logic flag,
                             input int iwait, input int dwait, input logic stop_dec);
        exp_t e;
        logic mem;
        pcconfig      = pc;
        ramconfig     = ram;
        regbankconfig = rb;
        regsource     = src;
        alu_flag      = flag;
        e.pc_sel      = (pc == 2'd1 && !flag) ? 2'd0 : pc;
        e.reg_write   = rb;
        e.reg_sel     = rb ? src : 2'd0;
        sb_q.push_back(e);
        mem = ram || (src == 2'd1);

        check("fetch_state", 32'(state), 32'(ST_FETCH));
        for (int i = 1; i <= iwait; i++) begin
            check("imem_req", 32'(imem_req), 32'd1);
            imem_ack = (i == iwait);
            #1;
            check("ir_load", 32'(ir_load), 32'(i == iwait));
            tick();
            imem_ack = 1'b0;
        end
        check("decode_state", 32'(state), 32'(ST_DECODE));
        if (stop_dec) stop = 1'b1;
        tick();
        stop = 1'b0;
        check("execute_state", 32'(state), 32'(ST_EXECUTE));
        check("execute_no_reg_write", 32'(reg_write), 32'd0);
        tick();
        if (mem) begin
            for (int j = 1; j <= dwait; j++) begin
                check("mem_state", 32'(state), 32'(ST_MEM));
                check("dmem_req", 32'(dmem_req), 32'd1);
                check("dmem_we", 32'(dmem_we), 32'(ram));
                dmem_ack = (j == dwait);
                tick();
                dmem_ack = 1'b0;
            end
        end
        if (rb) begin
            check("wb_state", 32'(state), 32'(ST_WRITEBACK));
            check("wb_reg_write", 32'(reg_write), 32'd1);
            check("wb_reg_sel", 32'(reg_sel), 32'(src));
            tick();
        end
        check("after_state", 32'(state), stop_dec ? 32'(ST_IDLE) : 32'(ST_FETCH));
        check("sb_drained", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        pcconfig = 2'd0; ramconfig = 1'b0; regbankconfig = 1'b0; regsource = 2'd0;
        alu_flag = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        tick();
        tick();
        check("rst_state", 32'(state), 32'(ST_IDLE));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        check("rst_pc_write", 32'(pc_write), 32'd0);
        reset = 1'b0;

        // start together with stop: stop wins, stay idle
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("start_stop_idle", 32'(state), 32'(ST_IDLE));
        check("start_stop_busy", 32'(busy), 32'd0);

        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_busy", 32'(busy), 32'd1);
        //        pc    ram   rb    src   flag  iw  dw  stop
        run_instr(2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1,  0, 1'b0);  // ALU R-type
        run_instr(2'd0, 1'b0, 1'b1, 2'd1, 1'b0, 2,  3, 1'b0);  // load
        run_instr(2'd1, 1'b0, 1'b0, 2'd0, 1'b1, 2,  0, 1'b0);  // branch taken
        run_instr(2'd1, 1'b0, 1'b0, 2'd0, 1'b0, 1,  0, 1'b0);  // branch not taken
        run_instr(2'd2, 1'b0, 1'b0, 2'd0, 1'b0, 1,  0, 1'b0);  // jump
        run_instr(2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1,  2, 1'b0);  // store
        run_instr(2'd2, 1'b0, 1'b1, 2'd2, 1'b1, 1,  0, 1'b1);  // link, stop in DECODE
        check("stopped_busy", 32'(busy), 32'd0);

        // acks while idle are ignored
        imem_ack = 1'b1; dmem_ack = 1'b1;
        #1;
        check("idle_ir_load", 32'(ir_load), 32'd0);
        check("idle_pc_write", 32'(pc_write), 32'd0);
        tick();
        imem_ack = 1'b0; dmem_ack = 1'b0;
        check("idle_ack_state", 32'(state), 32'(ST_IDLE));

        start = 1'b1;
        tick();
        start = 1'b0;
        run_instr(2'd0, 1'b0, 1'b1, 2'd0, 1'b0, TIMEOUT, 0, 1'b0);        // fetch ack in last cycle
        run_instr(2'd0, 1'b0, 1'b1, 2'd1, 1'b0, 1, TIMEOUT, 1'b0);        // mem ack in last cycle

        // reset while a load waits in MEM
        pcconfig = 2'd0; ramconfig = 1'b0; regbankconfig = 1'b1; regsource = 2'd1;
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        tick();
        tick();
        check("pre_rst_mem_state", 32'(state), 32'(ST_MEM));
        check("pre_rst_dmem_req", 32'(dmem_req), 32'd1);
        check("pre_rst_retired", 32'(retired), 32'(exp_retired));
        reset = 1'b1;
        tick();
        check("mid_rst_state", 32'(state), 32'(ST_IDLE));
        check("mid_rst_dmem_req", 32'(dmem_req), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_retired", 32'(retired), 32'd0);
        #1;
        check("mid_rst_pc_write", 32'(pc_write), 32'd0);
        check("mid_rst_reg_write", 32'(reg_write), 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_state", 32'(state), 32'(ST_IDLE));

        // fetch never acknowledged -> FAULT after TIMEOUT cycles
        pcconfig = 2'd0; ramconfig = 1'b0; regbankconfig = 1'b1; regsource = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            check("to_fetch_state", 32'(state), 32'(ST_FETCH));
            tick();
        end
        check("fault_state", 32'(state), 32'(ST_FAULT));
        check("fault_flag", 32'(fault), 32'd1);
        check("fault_busy", 32'(busy), 32'd0);
        check("fault_imem_req", 32'(imem_req), 32'd0);
        start = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("fault_ir_load", 32'(ir_load), 32'd0);
            check("fault_pc_write", 32'(pc_write), 32'd0);
            tick();
            check("fault_hold", 32'(state), 32'(ST_FAULT));
        end
        start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("fault_cleared_state", 32'(state), 32'(ST_IDLE));
        check("fault_cleared_flag", 32'(fault), 32'd0);

        // 16 instructions wrap a 4-bit retire counter back to zero
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            run_instr(2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1, 0, (k == 15));
        end
        check("wrap_retired", 32'(retired), 32'd0);
        check("wrap_state", 32'(state), 32'(ST_IDLE));
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
